// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer producing cpu_en for the single-cycle CPU datapath.
// Define RUNCTRL_WDT_EN to add the RUN-state watchdog stop; without it wdt_fired is tied low.
module cpu_run_ctrl #(
    parameter int CNT_W     = 16,
    parameter int WDT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [7:0]       cmd_arg,
    input  logic [7:0]       pc,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic             step_done,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             wdt_fired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_BRK  = 3'd3,
        S_HLT  = 3'd4
    } state_t;

    localparam logic [2:0] CMD_RUN     = 3'd1;
    localparam logic [2:0] CMD_STOP    = 3'd2;
    localparam logic [2:0] CMD_STEP    = 3'd3;
    localparam logic [2:0] CMD_SET_BP  = 3'd4;
    localparam logic [2:0] CMD_CLR_BP  = 3'd5;
    localparam logic [2:0] CMD_CLR_CNT = 3'd6;

    state_t           st;
    logic             bp_valid;
    logic [7:0]       bp_addr;
    logic             skip;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en;
    logic             bp_match;
    logic             accept;
    logic             acc_run, acc_stop, acc_step;
    logic             wdt_stop;

    assign bp_match = bp_valid && (pc == bp_addr);
    assign accept   = cmd_valid && cmd_ready;
    assign acc_run  = accept && (cmd == CMD_RUN);
    assign acc_stop = accept && (cmd == CMD_STOP);
    assign acc_step = accept && (cmd == CMD_STEP);

    always_comb begin
        en = 1'b0;
        if (!reset) begin
            case (st)
                S_RUN:   en = !(bp_match && !skip);
                S_STEP:  en = 1'b1;
                default: en = 1'b0;
            endcase
        end
    end

    assign cpu_en     = en;
    assign cmd_ready  = !reset && (st != S_STEP);
    assign state      = st;
    assign bp_hit     = !reset && (st == S_BRK);
    assign step_done  = !reset && done_q;
    assign retire_cnt = cnt_q;

`ifdef RUNCTRL_WDT_EN
    logic [15:0] wdt_cnt;
    logic        wdt_flag;

    // halt_in outranks the watchdog; a breakpoint already forces en low
    assign wdt_stop  = (st == S_RUN) && en && !halt_in && (wdt_cnt == 16'(WDT_LIMIT));
    assign wdt_fired = !reset && wdt_flag;

    always_ff @(posedge clk) begin
        if (reset || st != S_RUN) begin
            wdt_cnt <= '0;
        end else if (en) begin
            wdt_cnt <= wdt_cnt + 16'd1;
        end

        if (reset) begin
            wdt_flag <= 1'b0;
        end else if (wdt_stop) begin
            wdt_flag <= 1'b1;
        end else if (acc_run || acc_step) begin
            wdt_flag <= 1'b0;
        end
    end
`else
    assign wdt_stop  = 1'b0;
    assign wdt_fired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_IDLE;
            bp_valid <= 1'b0;
            bp_addr  <= '0;
            skip     <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= (st == S_STEP);

            if (accept && cmd == CMD_CLR_CNT) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (accept && cmd == CMD_SET_BP) begin
                bp_addr  <= cmd_arg;
                bp_valid <= 1'b1;
            end else if (accept && cmd == CMD_CLR_BP) begin
                bp_valid <= 1'b0;
            end

            if (st == S_RUN && en) begin
                skip <= 1'b0;
            end

            case (st)
                S_IDLE: begin
                    if (acc_run) begin
                        st <= S_RUN;
                    end else if (acc_step) begin
                        st <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (bp_match && !skip) begin
                        st <= S_BRK;
                    end else if (halt_in) begin
                        st <= S_HLT;
                    end else if (wdt_stop) begin
                        st <= S_HLT;
                    end else if (acc_stop) begin
                        st   <= S_IDLE;
                        skip <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (halt_in) begin
                        st <= S_HLT;
                    end else begin
                        st   <= S_IDLE;
                        skip <= 1'b0;
                    end
                end
                S_BRK: begin
                    // skip lets the breakpointed instruction execute once on resume
                    if (acc_run) begin
                        st   <= S_RUN;
                        skip <= 1'b1;
                    end else if (acc_step) begin
                        st <= S_STEP;
                    end else if (acc_stop) begin
                        st   <= S_IDLE;
                        skip <= 1'b0;
                    end
                end
                S_HLT: begin
                    if (acc_stop) begin
                        st   <= S_IDLE;
                        skip <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized commands against a behavioural model.
// A second instance with a 4-bit counter exercises retire_cnt wrap-around cheaply.
module tb_cpu_run_ctrl;

    localparam int WDT_LIM = 10;

    localparam logic [2:0] C_NOP = 3'd0, C_RUN = 3'd1, C_STOP = 3'd2, C_STEP = 3'd3;
    localparam logic [2:0] C_SET_BP = 3'd4, C_CLR_BP = 3'd5, C_CLR_CNT = 3'd6;

    localparam logic [2:0] M_IDLE = 3'd0, M_RUN = 3'd1, M_STEP = 3'd2, M_BRK = 3'd3, M_HLT = 3'd4;

    logic        clk, reset, cmd_valid, halt_in;
    logic [2:0]  cmd;
    logic [7:0]  cmd_arg, pc;
    logic        cmd_ready, cpu_en, bp_hit, step_done, wdt_fired;
    logic [2:0]  state;
    logic [15:0] retire_cnt;

    logic        s_cmd_ready, s_cpu_en, s_bp_hit, s_step_done, s_wdt_fired;
    logic [2:0]  s_state;
    logic [3:0]  s_retire_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] loop_start, loop_end, halt_pc;
    logic       halt_arm;

    cpu_run_ctrl #(.CNT_W(16), .WDT_LIMIT(WDT_LIM)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_arg(cmd_arg), .pc(pc), .halt_in(halt_in), .cpu_en(cpu_en),
        .state(state), .bp_hit(bp_hit), .step_done(step_done),
        .retire_cnt(retire_cnt), .wdt_fired(wdt_fired)
    );

    cpu_run_ctrl #(.CNT_W(4), .WDT_LIMIT(WDT_LIM)) dut_small (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd(cmd), .cmd_arg(cmd_arg), .pc(pc), .halt_in(halt_in), .cpu_en(s_cpu_en),
        .state(s_state), .bp_hit(s_bp_hit), .step_done(s_step_done),
        .retire_cnt(s_retire_cnt), .wdt_fired(s_wdt_fired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

    // One clock of a simple datapath: pc advances when the controller enables it.
    task automatic tick();
        logic en_s;
        @(negedge clk);
        en_s = cpu_en;
        @(posedge clk);
        #1;
        if (en_s) pc = (pc == loop_end) ? loop_start : pc + 8'd1;
        if (halt_arm) halt_in = (pc == halt_pc);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_arg   = a;
        tick();
        cmd_valid = 1'b0;
        cmd       = C_NOP;
        cmd_arg   = 8'd0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; cmd_arg = 8'd0;
        halt_in = 1'b0; halt_arm = 1'b0; halt_pc = 8'd0;
        pc = 8'd0; loop_start = 8'd0; loop_end = 8'd255;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
        checks++; if (state !== M_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        checks++; if ({bp_hit, step_done, wdt_fired} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bp_hit, step_done, wdt_fired}); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_breakpoint();
        send(C_SET_BP, 8'h05);
        send(C_RUN, 8'd0);
        checks++; if (state !== M_RUN || cpu_en !== 1'b1) begin errors++; $display("FAIL run_start got state %0d en %b want 1 1", state, cpu_en); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pc !== 8'd5 || cpu_en !== 1'b0) begin errors++; $display("FAIL bp_block got pc %0d en %b want 5 0", pc, cpu_en); end
        for (int i = 0; i < 20 && state !== M_BRK; i++) tick();
        checks++; if (state !== M_BRK || bp_hit !== 1'b1) begin errors++; $display("FAIL bp_state got state %0d bp_hit %b want 3 1", state, bp_hit); end
        checks++; if (retire_cnt !== 16'd5 || pc !== 8'd5) begin errors++; $display("FAIL bp_retire got cnt %0d pc %0d want 5 5", retire_cnt, pc); end
    endtask

    task automatic test_skip();
        loop_start = 8'd5; loop_end = 8'd6;
        send(C_RUN, 8'd0);
        checks++; if (state !== M_RUN || cpu_en !== 1'b1) begin errors++; $display("FAIL skip_resume got state %0d en %b want 1 1", state, cpu_en); end
        tick();
        checks++; if (retire_cnt !== 16'd6 || state !== M_RUN) begin errors++; $display("FAIL skip_retire got cnt %0d state %0d want 6 1", retire_cnt, state); end
        tick();
        checks++; if (pc !== 8'd5 || cpu_en !== 1'b0) begin errors++; $display("FAIL skip_rebreak_en got pc %0d en %b want 5 0", pc, cpu_en); end
        tick();
        checks++; if (state !== M_BRK || retire_cnt !== 16'd7) begin errors++; $display("FAIL skip_rebreak got state %0d cnt %0d want 3 7", state, retire_cnt); end
    endtask

    task automatic test_step();
        send(C_STOP, 8'd0);
        checks++; if (state !== M_IDLE) begin errors++; $display("FAIL brk_stop got state %0d want 0", state); end
        send(C_CLR_BP, 8'd0);
        send(C_STEP, 8'd0);
        checks++; if (state !== M_STEP || cmd_ready !== 1'b0 || cpu_en !== 1'b1 || step_done !== 1'b0)
            begin errors++; $display("FAIL step_active got st %0d rdy %b en %b done %b want 2 0 1 0", state, cmd_ready, cpu_en, step_done); end
        tick();
        checks++; if (state !== M_IDLE || cpu_en !== 1'b0 || step_done !== 1'b1 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL step_done got st %0d en %b done %b rdy %b want 0 0 1 1", state, cpu_en, step_done, cmd_ready); end
        checks++; if (retire_cnt !== 16'd8) begin errors++; $display("FAIL step_retire got %0d want 8", retire_cnt); end
        tick();
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL step_pulse got %b want 0", step_done); end
    endtask

    task automatic test_halt();
        loop_start = 8'd0; loop_end = 8'd255; pc = 8'd0;
        halt_arm = 1'b1; halt_pc = 8'd3; halt_in = 1'b0;
        send(C_RUN, 8'd0);
        for (int i = 0; i < 20 && state !== M_HLT; i++) tick();
        checks++; if (state !== M_HLT || cpu_en !== 1'b0 || pc !== 8'd4)
            begin errors++; $display("FAIL halt got st %0d en %b pc %0d want 4 0 4", state, cpu_en, pc); end
        checks++; if (retire_cnt !== 16'd12) begin errors++; $display("FAIL halt_retire got %0d want 12", retire_cnt); end
        send(C_RUN, 8'd0);
        checks++; if (state !== M_HLT) begin errors++; $display("FAIL halt_ignore_run got %0d want 4", state); end
        send(C_STOP, 8'd0);
        checks++; if (state !== M_IDLE) begin errors++; $display("FAIL halt_stop got %0d want 0", state); end
        halt_arm = 1'b0; halt_in = 1'b0;
    endtask

    task automatic test_clr_cnt();
        send(C_CLR_CNT, 8'd0);
        send(C_STEP, 8'd0);
        tick();
        send(C_RUN, 8'd0);
        for (int i = 0; i < 8; i++) tick();
        checks++; if (retire_cnt !== 16'd9 || cpu_en !== 1'b1) begin errors++; $display("FAIL clr_pre got cnt %0d en %b want 9 1", retire_cnt, cpu_en); end
        send(C_CLR_CNT, 8'd0);
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins got %0d want 0", retire_cnt); end
        send(C_STOP, 8'd0);
        checks++; if (state !== M_IDLE || retire_cnt !== 16'd1) begin errors++; $display("FAIL stop_exec got st %0d cnt %0d want 0 1", state, retire_cnt); end
    endtask

    task automatic test_wrap();
        send(C_CLR_CNT, 8'd0);
        for (int i = 0; i < 15; i++) begin
            send(C_STEP, 8'd0);
            tick();
        end
        checks++; if (s_retire_cnt !== 4'hF) begin errors++; $display("FAIL wrap_pre got %0d want 15", s_retire_cnt); end
        send(C_STEP, 8'd0);
        tick();
        checks++; if (s_retire_cnt !== 4'h0 || retire_cnt !== 16'd16) begin errors++; $display("FAIL wrap got small %0d main %0d want 0 16", s_retire_cnt, retire_cnt); end
    endtask

`ifdef RUNCTRL_WDT_EN
    task automatic test_watchdog();
        pc = 8'd0;
        send(C_CLR_CNT, 8'd0);
        send(C_RUN, 8'd0);
        for (int i = 0; i < 40 && state !== M_HLT; i++) tick();
        checks++; if (state !== M_HLT || wdt_fired !== 1'b1) begin errors++; $display("FAIL wdt_trip got st %0d wdt %b want 4 1", state, wdt_fired); end
        checks++; if (retire_cnt !== 16'(WDT_LIM + 1)) begin errors++; $display("FAIL wdt_count got %0d want %0d", retire_cnt, WDT_LIM + 1); end
        send(C_STEP, 8'd0);
        checks++; if (wdt_fired !== 1'b0 || state !== M_HLT) begin errors++; $display("FAIL wdt_clear got wdt %b st %0d want 0 4", wdt_fired, state); end
        send(C_STOP, 8'd0);
    endtask
`endif

    task automatic test_random();
        logic [2:0]  m_state, nxt, c;
        logic        m_bpv, m_skip, m_done, m_wf;
        logic [7:0]  m_bpa, a;
        logic [15:0] m_cnt;
        int          m_run;
        logic        v, h, match, en, rdy, acc, trip;

        do_reset();
        reset = 1'b0;
        loop_end = 8'd15;
        m_state = M_IDLE; m_bpv = 0; m_bpa = 0; m_skip = 0; m_done = 0; m_cnt = 0; m_wf = 0; m_run = 0;

        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) == 0);
            c = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 15));
            h = ($urandom_range(0, 15) == 0);
            cmd_valid = v; cmd = c; cmd_arg = a; halt_in = h;
            #1;

            match = m_bpv && (pc == m_bpa);
            en    = (m_state == M_STEP) || (m_state == M_RUN && !(match && !m_skip));
            rdy   = (m_state != M_STEP);
            acc   = v && rdy;

            checks++; if (cpu_en !== en) begin errors++; $display("FAIL rnd_cpu_en cyc %0d got %b want %b", i, cpu_en, en); end
            checks++; if (cmd_ready !== rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, cmd_ready, rdy); end
            checks++; if (state !== m_state) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state, m_state); end
            checks++; if (bp_hit !== (m_state == M_BRK)) begin errors++; $display("FAIL rnd_bp_hit cyc %0d got %b want %b", i, bp_hit, m_state == M_BRK); end
            checks++; if (step_done !== m_done) begin errors++; $display("FAIL rnd_step_done cyc %0d got %b want %b", i, step_done, m_done); end
            checks++; if (retire_cnt !== m_cnt || s_retire_cnt !== m_cnt[3:0])
                begin errors++; $display("FAIL rnd_retire cyc %0d got %0d/%0d want %0d/%0d", i, retire_cnt, s_retire_cnt, m_cnt, m_cnt[3:0]); end
            checks++; if (wdt_fired !== m_wf) begin errors++; $display("FAIL rnd_wdt cyc %0d got %b want %b", i, wdt_fired, m_wf); end

`ifdef RUNCTRL_WDT_EN
            trip = (m_state == M_RUN) && en && !h && (m_run == WDT_LIM);
`else
            trip = 1'b0;
`endif
            nxt = m_state;
            if (m_state == M_IDLE) begin
                if (acc && c == C_RUN) nxt = M_RUN;
                else if (acc && c == C_STEP) nxt = M_STEP;
            end else if (m_state == M_RUN) begin
                if (!en) nxt = M_BRK;
                else if (h || trip) nxt = M_HLT;
                else if (acc && c == C_STOP) nxt = M_IDLE;
            end else if (m_state == M_STEP) begin
                nxt = h ? M_HLT : M_IDLE;
            end else if (m_state == M_BRK) begin
                if (acc && c == C_RUN) nxt = M_RUN;
                else if (acc && c == C_STEP) nxt = M_STEP;
                else if (acc && c == C_STOP) nxt = M_IDLE;
            end else if (acc && c == C_STOP) begin
                nxt = M_IDLE;
            end

            if (m_state == M_RUN && en) m_skip = 1'b0;
            if (m_state == M_BRK && nxt == M_RUN) m_skip = 1'b1;
            if (m_state != M_IDLE && nxt == M_IDLE) m_skip = 1'b0;

            if (trip) m_wf = 1'b1;
            else if (acc && (c == C_RUN || c == C_STEP)) m_wf = 1'b0;
            m_run = (m_state == M_RUN && nxt == M_RUN) ? m_run + (en ? 1 : 0) : 0;

            if (acc && c == C_CLR_CNT) m_cnt = 16'd0;
            else if (en) m_cnt = m_cnt + 16'd1;
            if (acc && c == C_SET_BP) begin m_bpv = 1'b1; m_bpa = a; end
            else if (acc && c == C_CLR_BP) m_bpv = 1'b0;
            m_done  = (m_state == M_STEP);
            m_state = nxt;

            tick();
        end
        cmd_valid = 1'b0; cmd = C_NOP; halt_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_skip();
        test_step();
        test_halt();
        test_clr_cnt();
        test_wrap();
`ifdef RUNCTRL_WDT_EN
        test_watchdog();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/breakpoint sequencer for the 8-bit-PC, 16-bit single-cycle CPU datapath. It produces one enable, cpu_en, that gates the PC register, register-file write and data-memory write. A host or debug port drives it through a valid/ready command interface. It supports free-run, single-step, one PC breakpoint, halt-instruction detection and an instruction-retire counter.

Parameters:
CNT_W, 16, width of retire_cnt.
WDT_LIMIT, 255, consecutive RUN cycles before watchdog stop. Used only with RUNCTRL_WDT_EN; 16-bit compare.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd  in  3  command code: 0 NOP, 1 RUN, 2 STOP, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved (treated as NOP)
cmd_arg  in  8  breakpoint address for SET_BP
pc  in  8  current datapath PC
halt_in  in  1  decoded halt for the instruction at pc
cpu_en  out  1  datapath advances one instruction at next edge
state  out  3  0 IDLE, 1 RUN, 2 STEP, 3 BRK, 4 HLT
bp_hit  out  1  high while state==BRK
step_done  out  1  one-cycle pulse after a step retires
retire_cnt  out  CNT_W  count of cycles with cpu_en=1
wdt_fired  out  1  watchdog stop flag (tied 0 without the macro)

Behaviour:
- Reset: state IDLE. cpu_en, cmd_ready, bp_hit, step_done, wdt_fired all 0 during reset. bp_valid=0, bp_addr=0, skip=0, retire_cnt=0. The controller does not reset the PC.
- Command accept: cmd_valid && cmd_ready at a rising edge. cmd_ready=1 in every state except STEP and during reset.
- bp_match = bp_valid && pc==bp_addr. cpu_en is combinational:
  - RUN: cpu_en = !(bp_match && !skip).
  - STEP: cpu_en = 1.
  - All other states: cpu_en = 0.
  - A breakpointed instruction is not executed.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - STOP is a no-op.
- RUN, priority order:
  1. bp_match && !skip -> BRK.
  2. cpu_en && halt_in -> HLT. Wins over a STOP command in the same cycle.
  3. Accepted STOP -> IDLE. The instruction in the accept cycle still executes.
  4. Otherwise stay in RUN.
- STEP:
  - Lasts exactly one cycle with cpu_en=1; breakpoints ignored.
  - Next state is HLT if halt_in, else IDLE.
  - step_done=1 in the following cycle only.
- BRK:
  - RUN -> RUN and sets skip=1.
  - STEP -> STEP.
  - STOP -> IDLE.
- HLT:
  - Only STOP has an effect (-> IDLE).
  - RUN and STEP are accepted and ignored.
- skip:
  - Cleared at the first RUN-state edge where cpu_en=1.
  - Cleared on any transition to IDLE.
- SET_BP, CLR_BP, CLR_CNT:
  - Legal in any state that asserts cmd_ready.
  - SET_BP loads bp_addr=cmd_arg and sets bp_valid=1.
  - CLR_BP clears bp_valid.
- retire_cnt:
  - +1 each edge with cpu_en=1; wraps modulo 2^CNT_W.
  - CLR_CNT and an increment in the same cycle -> 0 (clear wins).
- SET_BP landing on the current pc while in RUN takes effect on the next cycle's compare.

Optional Feature:
Macro RUNCTRL_WDT_EN.
- Defined:
  - A 16-bit run counter increments on each RUN cycle with cpu_en=1.
  - Counter clears on leaving RUN and on reset.
  - When the counter equals WDT_LIMIT with cpu_en=1, that instruction executes, then the state goes to HLT and wdt_fired=1.
  - wdt_fired clears on the next accepted RUN or STEP.
  - halt_in and bp_match take precedence over the watchdog.
- Undefined: no counter; wdt_fired is constant 0.

Test Plan:
- Reset, SET_BP 0x05, RUN, pc increments from 0 on cpu_en -> cpu_en high for pc 0..4, low at pc=5; state=3, bp_hit=1, retire_cnt=5.
- From BRK at pc=5, RUN -> cpu_en=1 at pc=5 (skip), state=1, retire_cnt=6 after that edge; with the loop back to pc=5 and skip cleared, re-breaks.
- IDLE, STEP -> cmd_ready=0 and cpu_en=1 for exactly one cycle; step_done pulses one cycle later; state returns to 0; retire_cnt +1.
- RUN with halt_in=1 at pc=3 -> pc=3 executes, state=4, cpu_en=0; RUN ignored; STOP -> state=0.
- CLR_CNT accepted on a cycle with cpu_en=1 and retire_cnt=9 -> retire_cnt=0 next cycle. retire_cnt at 0xFFFF plus one retire -> 0x0000.
- RUNCTRL_WDT_EN with WDT_LIMIT=10, RUN, no bp -> exactly 11 cpu_en cycles, then state=4, wdt_fired=1; STEP clears wdt_fired.
